single_dot_v_m_seq: RTL and testbench
=====================================

// Module: single_dot_v_m_seq
// PURPOSE
//  Time-multiplexed single-precision (IEEE-754 binary32) matrix-vector product for NN layers:
//  vector_out[r] = act(sum_c matrix[r][c]*vector[c] + bias[r]).
//  LANES MAC units process LANES rows at a time, so area trades against latency.
//  Sits between layer weight storage and the next layer; start/busy/done handshake.
// PARAMETERS
//  WIDTH   5  input vector length (columns); >=1
//  HEIGHT  5  output vector length (rows); >=1
//  LANES   1  parallel MAC lanes; HEIGHT % LANES == 0 (elaboration error otherwise)
// PORTS
//  clk         in   1               rising-edge clock
//  rstn        in   1               asynchronous active-low reset
//  start       in   1               request; sampled only in IDLE
//  bias_en     in   1               add bias[] to results; latched with start
//  relu_en     in   1               apply ReLU to results; latched with start
//  vector      in   32 x WIDTH      input vector, binary32
//  matrix      in   32 x HEIGHT x WIDTH  matrix[r][c], binary32
//  bias        in   32 x HEIGHT     bias, binary32
//  busy        out  1               high from the edge accepting start until the edge raising done
//  done        out  1               single-cycle completion pulse
//  vector_out  out  32 x HEIGHT     results, binary32; held until next completion
// BEHAVIOUR
//  Reset: busy=0, done=0, vector_out all 0x00000000, state IDLE, accumulators +0.0.
//  Reset mid-operation aborts immediately; partial results are discarded.
//  States: IDLE -> MAC -> FIN -> (MAC | IDLE). G = HEIGHT/LANES groups.
//  IDLE: on start=1, latch vector, matrix, bias, bias_en, relu_en; grp=0, col=0; acc[*]=+0.0;
//    busy<=1; -> MAC. Inputs may change after this edge without effect.
//  MAC (WIDTH cycles): acc[l] <= acc[l] + matrix[grp*LANES+l][col]*vector[col]; col++.
//    Product and sum each rounded (not fused), columns summed strictly in order 0..WIDTH-1.
//    After col==WIDTH-1 -> FIN.
//  FIN (1 cycle): res[grp*LANES+l] <= post(acc[l]); acc[*]<=+0.0; col<=0.
//    post(x): x + bias[r] if bias_en, then +0.0 if relu_en and sign bit set (covers -0.0, -inf, -NaN).
//    grp<G-1: grp++, -> MAC. grp==G-1: copy all of res to vector_out, done<=1, busy<=0, -> IDLE.
//  Latency: done high G*(WIDTH+1) edges after the accepting edge (W=H=5, L=1: 30; L=5: 6).
//  vector_out changes only on the edge raising done; never partially updated.
//  start while busy (MAC/FIN) ignored, not queued. start high in the cycle done is high
//    is accepted at the next edge (IDLE); back-to-back throughput = one job per G*(WIDTH+1)+1 cycles.
//  start held high continuously: new job accepted each time IDLE is reached.
//  Arithmetic: round-to-nearest-even; denormal inputs and results flushed to +/-0;
//    overflow -> +/-inf; inf-inf and 0*inf -> quiet NaN 0x7FC00000; NaN propagates.
//    Exact zero sums are +0.0.
//  Floating-point units are the team's existing combinational binary32 add/multiply primitives,
//    LANES multipliers + LANES adders; the bias add in FIN reuses the lane adders.
// TESTING
//  1 W=H=5 L=1; vector 1..5, every row 1,2,3,4,5, bias_en=0 -> all outputs 55.0 (0x425C0000);
//    done pulse exactly 30 edges after start accepted; busy high those 30 cycles.
//  2 Same stimulus, L=5 -> same outputs, done after 6 edges; L=1 vs L=5 bit-identical.
//  3 Test 1 data, bias all -60.0, bias_en=1: relu_en=0 -> all -5.0 (0xC0A00000);
//    relu_en=1 -> all 0x00000000.
//  4 Identity matrix, vector {1.5,-2.0,0.0,3.25,-0.0}, relu_en=1 -> {1.5,0,0,3.25,0};
//    change vector/matrix and pulse start during busy -> no effect, only one done.
//  5 Reset asserted 10 cycles into a job -> busy=0, done=0, vector_out=0 at once;
//    after release, new job (test 1 data) completes normally in 30 cycles.
//  6 Row with 3.0e38 twice, vector 1.0,1.0 -> +inf (0x7F800000); row {inf,-inf} -> 0x7FC00000.

Source files
------------

// File: rtl/single_dot_v_m_seq.sv
// Time-multiplexed binary32 matrix-vector product with optional bias and ReLU.
// LANES multiply-accumulate lanes walk the rows in groups; one column per cycle.
module single_dot_v_m_seq #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      bias_en,
    input  logic                      relu_en,
    input  logic [32*WIDTH-1:0]       vector,
    input  logic [32*HEIGHT*WIDTH-1:0] matrix,
    input  logic [32*HEIGHT-1:0]      bias,
    output logic                      busy,
    output logic                      done,
    output logic [32*HEIGHT-1:0]      vector_out
);

    localparam int G  = HEIGHT / LANES;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(G + 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    generate
        if (HEIGHT % LANES != 0) begin : g_bad_lanes
            $error("HEIGHT must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

    // Round-to-nearest-even on a normalised 24-bit significand, then overflow/flush.
    function automatic logic [31:0] pack_round(input logic sign, input logic signed [11:0] exp_in,
                                               input logic [23:0] mant, input logic guard,
                                               input logic sticky);
        logic [24:0] m;
        logic signed [11:0] e;
        logic [31:0] r;
        m = {1'b0, mant} + 25'(guard & (sticky | mant[0]));
        e = exp_in;
        if (m[24]) begin
            m = m >> 1;
            e = e + 12'sd1;
        end
        if (e >= 12'sd255)    r = {sign, 8'hFF, 23'd0};
        else if (e <= 12'sd0) r = {sign, 31'd0};
        else                  r = {sign, e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0] prod;
        logic signed [11:0] e;
        logic [31:0] r;
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) r = QNAN;
        else if (a_inf || b_inf)   r = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero) r = {sign, 31'd0};
        else if (prod[47])         r = pack_round(sign, e + 12'sd1, prod[47:24], prod[23], |prod[22:0]);
        else                       r = pack_round(sign, e, prod[46:23], prod[22], |prod[21:0]);
        return r;
    endfunction

    // Three guard bits plus a sticky bit folded into the aligned smaller operand.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, found, sticky;
        logic [31:0] x, y, r;
        logic [7:0] d;
        logic [26:0] mx, my, sh;
        logic [27:0] s;
        logic signed [11:0] e;
        int lz;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        r = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) r = QNAN;
        else if (a_inf)             r = {a[31], 8'hFF, 23'd0};
        else if (b_inf)             r = {b[31], 8'hFF, 23'd0};
        else if (a_zero && b_zero)  r = 32'd0;
        else if (a_zero)            r = b;
        else if (b_zero)            r = a;
        else begin
            if (a[30:0] >= b[30:0]) begin
                x = a;
                y = b;
            end else begin
                x = b;
                y = a;
            end
            d  = x[30:23] - y[30:23];
            mx = {1'b1, x[22:0], 3'b000};
            my = {1'b1, y[22:0], 3'b000};
            if (d >= 8'd27) begin
                sh = 27'd1;
            end else begin
                sticky = |(my & ~({27{1'b1}} << d));
                sh     = (my >> d) | {26'd0, sticky};
            end
            e = $signed({4'd0, x[30:23]});
            if (x[31] == y[31]) begin
                s = {1'b0, mx} + {1'b0, sh};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 12'sd1;
                end
            end else begin
                s = {1'b0, mx} - {1'b0, sh};
            end
            if (s != 28'd0) begin
                found = 1'b0;
                lz    = 0;
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (s[i]) found = 1'b1;
                        else      lz++;
                    end
                end
                s = s << lz;
                e = e - $signed(12'(lz));
                r = pack_round(x[31], e, s[26:3], s[2], |s[1:0]);
            end
        end
        return r;
    endfunction

    state_t          state;
    logic [CW-1:0]   col;
    logic [GW-1:0]   grp;
    logic            bias_en_r, relu_en_r;
    logic [31:0]     mat_r [HEIGHT][WIDTH];
    logic [31:0]     vec_r [WIDTH];
    logic [31:0]     bias_r [HEIGHT];
    logic [31:0]     res [HEIGHT];
    logic [31:0]     next_res [HEIGHT];
    logic [31:0]     acc [LANES];
    logic [31:0]     m_sel [LANES];
    logic [31:0]     b_sel [LANES];
    logic [31:0]     addend [LANES];
    logic [31:0]     add_out [LANES];
    logic [31:0]     post [LANES];
    logic [31:0]     v_sel;

    // Lane adders accumulate products in MAC and add the bias in FIN.
    always_comb begin
        v_sel = 32'd0;
        for (int c = 0; c < WIDTH; c++)
            if (int'(col) == c) v_sel = vec_r[c];
        for (int l = 0; l < LANES; l++) begin
            m_sel[l] = 32'd0;
            b_sel[l] = 32'd0;
            for (int r = 0; r < HEIGHT; r++) begin
                if (int'(grp) * LANES + l == r) b_sel[l] = bias_r[r];
                for (int c = 0; c < WIDTH; c++)
                    if (int'(grp) * LANES + l == r && int'(col) == c) m_sel[l] = mat_r[r][c];
            end
            addend[l]  = (state == FIN) ? b_sel[l] : fp_mul(m_sel[l], v_sel);
            add_out[l] = fp_add(acc[l], addend[l]);
            post[l]    = bias_en_r ? add_out[l] : acc[l];
            if (relu_en_r && post[l][31]) post[l] = 32'd0;
        end
        next_res = res;
        for (int r = 0; r < HEIGHT; r++)
            for (int l = 0; l < LANES; l++)
                if (int'(grp) * LANES + l == r) next_res[r] = post[l];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            col        <= '0;
            grp        <= '0;
            bias_en_r  <= 1'b0;
            relu_en_r  <= 1'b0;
            vector_out <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= 32'd0;
            for (int c = 0; c < WIDTH; c++) vec_r[c] <= 32'd0;
            for (int r = 0; r < HEIGHT; r++) begin
                res[r]    <= 32'd0;
                bias_r[r] <= 32'd0;
                for (int c = 0; c < WIDTH; c++) mat_r[r][c] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int c = 0; c < WIDTH; c++) vec_r[c] <= vector[c*32 +: 32];
                    for (int r = 0; r < HEIGHT; r++) begin
                        bias_r[r] <= bias[r*32 +: 32];
                        for (int c = 0; c < WIDTH; c++) mat_r[r][c] <= matrix[(r*WIDTH+c)*32 +: 32];
                    end
                    for (int l = 0; l < LANES; l++) acc[l] <= 32'd0;
                    bias_en_r <= bias_en;
                    relu_en_r <= relu_en;
                    grp       <= '0;
                    col       <= '0;
                    busy      <= 1'b1;
                    state     <= MAC;
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) acc[l] <= add_out[l];
                    if (col == CW'(WIDTH - 1)) state <= FIN;
                    else                       col   <= col + CW'(1);
                end
                FIN: begin
                    res <= next_res;
                    for (int l = 0; l < LANES; l++) acc[l] <= 32'd0;
                    col <= '0;
                    if (grp == GW'(G - 1)) begin
                        for (int r = 0; r < HEIGHT; r++) vector_out[r*32 +: 32] <= next_res[r];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        grp   <= grp + GW'(1);
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_single_dot_v_m_seq.sv
// Scoreboarded bench: one-lane and five-lane instances share stimulus and are
// checked against a real-arithmetic binary32 reference model.
module tb_single_dot_v_m_seq;

    localparam int W = 5;
    localparam int H = 5;
    localparam int LAT1 = 30;
    localparam int LAT5 = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic bias_en = 1'b0;
    logic relu_en = 1'b0;
    logic [32*W-1:0]   vector = '0;
    logic [32*H*W-1:0] matrix = '0;
    logic [32*H-1:0]   bias = '0;
    logic busy1, done1, busy5, done5;
    logic [32*H-1:0] vout1, vout5;

    logic [31:0] tv [W];
    logic [31:0] tm [H][W];
    logic [31:0] tbias [H];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int bcnt1 = 0;
    int bcnt5 = 0;

    typedef struct {
        logic [32*H-1:0] vout;
        int              done_cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q5[$];
    exp_t e1, e5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    single_dot_v_m_seq #(.WIDTH(W), .HEIGHT(H), .LANES(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .bias_en(bias_en), .relu_en(relu_en),
        .vector(vector), .matrix(matrix), .bias(bias),
        .busy(busy1), .done(done1), .vector_out(vout1));

    single_dot_v_m_seq #(.WIDTH(W), .HEIGHT(H), .LANES(5)) dut5 (
        .clk(clk), .rstn(rstn), .start(start), .bias_en(bias_en), .relu_en(relu_en),
        .vector(vector), .matrix(matrix), .bias(bias),
        .busy(busy5), .done(done5), .vector_out(vout5));

    function automatic bit is_zero(input logic [31:0] x); return x[30:23] == 8'd0; endfunction
    function automatic bit is_inf(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] == 23'd0; endfunction
    function automatic bit is_nan(input logic [31:0] x);  return x[30:23] == 8'hFF && x[22:0] != 23'd0; endfunction

    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        if (is_zero(x)) return 0.0;
        d = {x[31], 11'({3'b000, x[30:23]}) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Nearest-even conversion of a double to binary32 with flush-to-zero.
    function automatic logic [31:0] from_real(input real v);
        logic [63:0] d;
        logic [24:0] m;
        int e;
        d = $realtobits(v);
        if (v == 0.0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 32'h7FC00000;
        if (is_inf(a) || is_inf(b))   return {s, 8'hFF, 23'd0};
        if (is_zero(a) || is_zero(b)) return {s, 31'd0};
        return from_real(to_real(a) * to_real(b));
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        real r;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return 32'h7FC00000;
        if (is_inf(a)) return {a[31], 8'hFF, 23'd0};
        if (is_inf(b)) return {b[31], 8'hFF, 23'd0};
        r = to_real(a) + to_real(b);
        if (r == 0.0) return 32'd0;
        return from_real(r);
    endfunction

    function automatic logic [32*H-1:0] expected_vout(input bit be, input bit re);
        logic [32*H-1:0] ev;
        logic [31:0] acc;
        for (int r = 0; r < H; r++) begin
            acc = 32'd0;
            for (int c = 0; c < W; c++) acc = model_add(acc, model_mul(tm[r][c], tv[c]));
            if (be) acc = model_add(acc, tbias[r]);
            if (re && acc[31]) acc = 32'd0;
            ev[r*32 +: 32] = acc;
        end
        return ev;
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 15) == 0) return 32'd0;
        return {r[31], 8'(120 + $urandom_range(0, 14)), r[22:0]};
    endfunction

    task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic pack_inputs();
        for (int r = 0; r < H; r++) begin
            bias[r*32 +: 32] = tbias[r];
            for (int c = 0; c < W; c++) matrix[(r*W+c)*32 +: 32] = tm[r][c];
        end
        for (int c = 0; c < W; c++) vector[c*32 +: 32] = tv[c];
    endtask

    task automatic apply_stimulus(input bit be, input bit re);
        exp_t e;
        @(negedge clk);
        pack_inputs();
        bias_en = be;
        relu_en = re;
        start   = 1'b1;
        e.vout = expected_vout(be, re);
        e.done_cyc = cyc + 1 + LAT1;
        q1.push_back(e);
        e.done_cyc = cyc + 1 + LAT5;
        q5.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_accept", {busy1, busy5}, 2'b11);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q1.size() != 0 || q5.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, required done within %0d", n, LAT1);
            q1.delete();
            q5.delete();
        end
        @(negedge clk);
    endtask

    task automatic score(input string tag, input bit have, input exp_t e, input logic [159:0] vout,
                         input logic busy_now, input int bc, input int lat);
        if (!have) begin
            n_vec++;
            n_bad++;
            $display("[TB] FAIL %s_unexpected_done: got done=1, required no pending job", tag);
        end else begin
            check_output({tag, "_vout"}, vout, e.vout);
            check_output({tag, "_done_cycle"}, cyc, e.done_cyc);
            check_output({tag, "_busy_at_done"}, busy_now, 0);
            check_output({tag, "_busy_cycles"}, bc, lat);
        end
    endtask

    // Monitor: each done pulse is matched against the oldest outstanding job.
    always @(negedge clk) begin
        if (rstn) begin
            if (busy1) bcnt1++;
            if (busy5) bcnt5++;
            if (done1) begin
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    score("L1", 1'b1, e1, vout1, busy1, bcnt1, LAT1);
                end else score("L1", 1'b0, e1, vout1, busy1, bcnt1, LAT1);
                bcnt1 = 0;
            end
            if (done5) begin
                if (q5.size() != 0) begin
                    e5 = q5.pop_front();
                    score("L5", 1'b1, e5, vout5, busy5, bcnt5, LAT5);
                end else score("L5", 1'b0, e5, vout5, busy5, bcnt5, LAT5);
                bcnt5 = 0;
            end
        end
    end

    task automatic load_counting_job();
        for (int c = 0; c < W; c++) tv[c] = from_real(real'(c + 1));
        for (int r = 0; r < H; r++) begin
            tbias[r] = 32'd0;
            for (int c = 0; c < W; c++) tm[r][c] = from_real(real'(c + 1));
        end
    endtask

    initial begin
        load_counting_job();
        repeat (3) @(negedge clk);
        check_output("reset_busy", {busy1, busy5}, 2'b00);
        check_output("reset_done", {done1, done5}, 2'b00);
        check_output("reset_vout1", vout1, '0);
        check_output("reset_vout5", vout5, '0);
        rstn = 1'b1;

        apply_stimulus(1'b0, 1'b0);
        wait_idle();
        check_output("dot_55_L1", vout1[31:0], 32'h425C0000);
        check_output("dot_55_L5", vout5[159:128], 32'h425C0000);

        for (int r = 0; r < H; r++) tbias[r] = 32'hC2700000;
        apply_stimulus(1'b1, 1'b0);
        wait_idle();
        check_output("bias_neg5", vout1[63:32], 32'hC0A00000);
        apply_stimulus(1'b1, 1'b1);
        wait_idle();
        check_output("bias_relu_zero", vout1, '0);

        tv = '{32'h3FC00000, 32'hC0000000, 32'h00000000, 32'h40500000, 32'h80000000};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tm[r][c] = (r == c) ? 32'h3F800000 : 32'h0;
        apply_stimulus(1'b0, 1'b1);
        for (int c = 0; c < W; c++) tv[c] = rnd_f();
        tm[0][0] = 32'h40000000;
        pack_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check_output("identity_relu",
                     vout1, {32'h0, 32'h40500000, 32'h0, 32'h0, 32'h3FC00000});

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tm[r][c] = (c < 2) ? 32'h0 : rnd_f();
        tm[0][0] = 32'h7F61B1E6;
        tm[0][1] = 32'h7F61B1E6;
        tm[1][0] = 32'h7F800000;
        tm[1][1] = 32'hFF800000;
        tv[0] = 32'h3F800000;
        tv[1] = 32'h3F800000;
        apply_stimulus(1'b0, 1'b0);
        wait_idle();
        check_output("overflow_inf", vout1[31:0], 32'h7F800000);
        check_output("inf_minus_inf", vout1[63:32], 32'h7FC00000);

        load_counting_job();
        apply_stimulus(1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_output("abort_busy_done", {busy1, done1, busy5, done5}, 4'b0000);
        check_output("abort_vout1", vout1, '0);
        check_output("abort_vout5", vout5, '0);
        q1.delete();
        q5.delete();
        @(negedge clk);
        rstn = 1'b1;
        bcnt1 = 0;
        bcnt5 = 0;
        apply_stimulus(1'b0, 1'b0);
        wait_idle();

        for (int j = 0; j < 30; j++) begin
            for (int c = 0; c < W; c++) tv[c] = rnd_f();
            for (int r = 0; r < H; r++) begin
                tbias[r] = rnd_f();
                for (int c = 0; c < W; c++) tm[r][c] = rnd_f();
            end
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
